// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: S-box, round constants, FSM states.
// Imported by the inverse key scheduler and its SubWord datapath.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
// Shared by the forward and inverse key-expansion steps.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {
        SBOX[word_in[31:24]],
        SBOX[word_in[23:16]],
        SBOX[word_in[15:8]],
        SBOX[word_in[7:0]]
    };

endmodule

// File: rtl/inv_key_scheduler.sv
// AES-128 key scheduler that expands forward to round 10, then walks the
// schedule backwards, handing out round keys 10..0 over a valid/ready port.
module inv_key_scheduler
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         key_start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_FWD = 4'(NR - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  sw_sel, sw_rot, sw_out, t_word;
    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;
    logic [127:0] fwd_key, inv_key;
    logic         in_rev;

    assign {w0, w1, w2, w3} = key_q;
    assign in_rev = (state_q == REV);

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // The inverse step needs the previous w3, which is recovered as p3.
    assign sw_sel = in_rev ? p3 : w3;
    assign sw_rot = {sw_sel[23:0], sw_sel[31:24]};

    aes_subword u_subword (
        .word_in  (sw_rot),
        .word_out (sw_out)
    );

    assign rcon_idx = in_rev ? (cnt_q - 4'd1) : cnt_q;
    assign rcon     = (rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;
    assign t_word   = sw_out ^ {rcon, 24'h0};

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0      = w0 ^ t_word;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        fwd_key = {f0, f1, f2, f3};
        inv_key = {w0 ^ t_word, p1, p2, p3};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_start) begin
                    key_d   = key_in;
                    cnt_d   = 4'd0;
                    state_d = FWD;
                end
            end
            FWD: begin
                key_d = fwd_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_FWD) begin
                    state_d = REV;
                end
            end
            REV: begin
                if (rk_ready) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = inv_key;
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            key_q   <= 128'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = in_rev;
    assign rk_out   = in_rev ? key_q : 128'h0;
    assign rk_round = in_rev ? cnt_q : 4'd0;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: doc/inv_key_scheduler.md
INV_KEY_SCHEDULER -- requirements
Module: inv_key_scheduler

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops update on the rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port key_start, input, 1 bit: request to begin a new schedule, sampled only in IDLE.
REQ-005 SHALL have port key_in, input, 128 bits: cipher key; [127:96] is word w0 and [31:0] is w3.
REQ-006 SHALL have port rk_ready, input, 1 bit: consumer accepts rk_out.
REQ-007 SHALL have port rk_valid, output, 1 bit: rk_out and rk_round hold a valid round key.
REQ-008 SHALL have port rk_out, output, 128 bits: round key, using the same word order as key_in.
REQ-009 SHALL have port rk_round, output, 4 bits: index of the round key on rk_out (10 down to 0).
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after round key 0 is accepted.

Function
REQ-012 SHALL implement the FSM states IDLE, FWD and REV.
REQ-013 IDLE with key_start=1 at an edge SHALL register key_in into the key register, clear the round counter to 0 and go to FWD.
REQ-014 FWD SHALL apply one forward expansion step per cycle: w0' = w0 ^ SubWord(RotWord(w3)) ^ {RCON[cnt],24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'; then cnt increments.
REQ-015 After the 10th FWD step the FSM SHALL go to REV with cnt=10, so rk_valid rises 10 edges after the accepting edge.
REQ-016 In REV, rk_valid SHALL be 1, rk_out SHALL equal the key register, and rk_round SHALL equal cnt.
REQ-017 In REV, on rk_valid & rk_ready with cnt>0, the key register SHALL take the inverse step and cnt SHALL decrement.
REQ-018 The inverse step SHALL be: p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0; p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[cnt-1],24'h0}.
REQ-019 In REV, on a handshake with cnt=0, the FSM SHALL go to IDLE and done SHALL be 1 for exactly the following cycle.
REQ-020 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL hold stable; there is no timeout.
REQ-021 key_start SHALL be ignored outside IDLE.
REQ-022 key_in SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-023 The forward and inverse steps SHALL share one SubWord datapath of 4 S-box lookups, with a mux on the word selected per state.
REQ-024 Exactly 11 handshakes SHALL occur per schedule, in round order 10 down to 0.
REQ-025 rk_valid SHALL be 0 in IDLE and FWD.
REQ-026 key_start=1 in the same cycle done=1 SHALL be accepted normally, since the FSM is in IDLE.

Reset
REQ-027 n_rst=0 SHALL asynchronously force state=IDLE, cnt=0, key register=0, rk_valid=0, rk_out=0, rk_round=0, busy=0 and done=0.
REQ-028 Reset asserted during FWD or REV SHALL abort the schedule with no further handshakes.
REQ-029 After reset deasserts, the FSM SHALL wait in IDLE for a new key_start.

Structure
REQ-030 The S-box table, the RCON[0:9] list (01,02,04,08,10,20,40,80,1b,36) and the state enum SHALL reside in the shared package aes_pkg.
REQ-031 A single sub-module, aes_subword (32-bit combinational SubWord built from the package table), SHALL be instantiated once.
REQ-032 All state SHALL use one always_ff block with asynchronous reset; next-state logic SHALL be always_comb.

Verification
REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1: the first rk_valid beat SHALL be round 10, d014f9a8c9ee2589e13f0cc8b6630ca6; the round 1 beat SHALL be a0fafe1788542cb123a339392a6c7605; the round 0 beat SHALL equal the key; done SHALL pulse once.
REQ-034 Same key with rk_ready randomly toggled: the bench SHALL see 11 beats with identical values, rk_out stable while stalled and rk_round strictly decreasing.
REQ-035 Key 000...0: round 10 SHALL be b4ef5bcb3e92e21123e951cf6f8f188e and round 0 SHALL be all zeros.
REQ-036 key_start pulsed during FWD with a different key_in: the output sequence SHALL be unchanged.
REQ-037 n_rst pulsed during REV at rk_round=5: outputs SHALL be 0 immediately, busy=0 and no done; a following key_start SHALL produce a correct full sequence.
REQ-038 key_start held high across done: a second schedule SHALL start at the next edge, with rk_valid 10 edges later.
